// File: rtl/rx_pkg.sv
// Shared types and constants for the serial-line triple sampler.
package rx_pkg;

    localparam int unsigned DEF_OSR   = 16;
    localparam int unsigned DEF_NBITS = 10;

    typedef enum logic [1:0] {
        StIdle,
        StHunt,
        StSample
    } rx_state_e;

    function automatic int unsigned ph_a(input int unsigned osr);
        return osr / 2 - 1;
    endfunction

    function automatic int unsigned ph_b(input int unsigned osr);
        return osr / 2;
    endfunction

    function automatic int unsigned ph_c(input int unsigned osr);
        return osr / 2 + 1;
    endfunction

    localparam int unsigned PH_A = DEF_OSR / 2 - 1;
    localparam int unsigned PH_B = DEF_OSR / 2;
    localparam int unsigned PH_C = DEF_OSR / 2 + 1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous level; resets to 1 (idle line).
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q, ff_d;

    always_comb begin
        ff_d = {ff_q[0], d_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/bit_triple_sampler.sv
// Hunts for a falling start edge on a serial line and samples each bit period
// three times around its centre, handing a/b/c triples to a downstream voter.
module bit_triple_sampler
    import rx_pkg::*;
#(
    parameter int unsigned OSR   = DEF_OSR,
    parameter int unsigned NBITS = DEF_NBITS,
    parameter int unsigned PW    = 4,
    parameter int unsigned IW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          arm,
    input  logic          din,
    output logic          a,
    output logic          b,
    output logic          c,
    output logic          valid,
    output logic [IW-1:0] bit_idx,
    output logic          busy,
    output logic          done
);

    if ((OSR % 2) != 0 || OSR < 4 || (2 ** PW) < OSR || (2 ** IW) < NBITS) begin : g_bad_params
        $error("bit_triple_sampler: OSR must be even and >= 4, and PW/IW wide enough");
    end

    localparam logic [PW-1:0] PhA     = PW'(ph_a(OSR));
    localparam logic [PW-1:0] PhB     = PW'(ph_b(OSR));
    localparam logic [PW-1:0] PhC     = PW'(ph_c(OSR));
    localparam logic [PW-1:0] PhLast  = PW'(OSR - 1);
    localparam logic [IW-1:0] IdxLast = IW'(NBITS - 1);

    logic din_s;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d_i (din),
        .q_o (din_s)
    );

    rx_state_e     state_q, state_d;
    logic          prev_q, prev_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic          a_q, a_d, b_q, b_d, c_q, c_d;
    logic          valid_q, valid_d, done_q, done_d, busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        phase_d   = phase_q;
        bit_idx_d = bit_idx_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A line already low when armed has to rise before it can start a frame.
                if (arm) begin
                    state_d = StHunt;
                    prev_d  = 1'b0;
                end
            end
            StHunt: begin
                if (!arm) begin
                    state_d = StIdle;
                end else if (tick) begin
                    prev_d = din_s;
                    if (prev_q && !din_s) begin
                        state_d   = StSample;
                        phase_d   = '0;
                        bit_idx_d = '0;
                    end
                end
            end
            StSample: begin
                if (tick) begin
                    if (phase_q == PhA) a_d = din_s;
                    if (phase_q == PhB) b_d = din_s;
                    if (phase_q == PhC) begin
                        c_d     = din_s;
                        valid_d = 1'b1;
                    end
                    if (phase_q == PhLast) begin
                        phase_d = '0;
                        if (bit_idx_q == IdxLast) begin
                            bit_idx_d = '0;
                            done_d    = 1'b1;
                            // Stop bit is high, so an immediate start edge is still seen.
                            prev_d    = 1'b1;
                            state_d   = arm ? StHunt : StIdle;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StSample);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            prev_q    <= 1'b1;
            phase_q   <= '0;
            bit_idx_q <= '0;
            a_q       <= 1'b1;
            b_q       <= 1'b1;
            c_q       <= 1'b1;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign c       = c_q;
    assign valid   = valid_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_bit_triple_sampler.sv
// Randomised bench for bit_triple_sampler: the line is described per tick and a
// tick-level model predicts every triple and done pulse.
module tb_bit_triple_sampler;

    localparam int OSR = 16;
    localparam int NBITS = 10;
    localparam int PW = 4;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, tick = 1'b0, arm = 1'b0, din = 1'b1;
    logic a, b, c, valid, busy, done;
    logic [IW-1:0] bit_idx;

    bit_triple_sampler #(.OSR(OSR), .NBITS(NBITS), .PW(PW), .IW(IW)) dut (
        .clk(clk), .rst(rst), .tick(tick), .arm(arm), .din(din),
        .a(a), .b(b), .c(c), .valid(valid), .bit_idx(bit_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {int tk; int idx; logic a; logic b; logic c;} trip_t;

    bit    line_q[$];
    bit    arm_q[$];
    trip_t got_q[$];
    int    done_got[$];
    int    tcnt = 0, wide = 0, clash = 0;
    bit    valid_d1 = 1'b0;
    int    errors = 0, checks = 0;

    // Records every triple and done pulse with the index of the tick that caused it.
    always @(negedge clk) begin
        if (valid) got_q.push_back('{tcnt - 1, int'(bit_idx), a, b, c});
        if (done) done_got.push_back(tcnt - 1);
        if (valid && valid_d1) wide++;
        if (valid && done) clash++;
        valid_d1 = valid;
        if (tick && !rst) tcnt++;
    end

    function automatic string fmt(input trip_t t);
        return $sformatf("tick=%0d idx=%0d abc=%b%b%b", t.tk, t.idx, t.a, t.b, t.c);
    endfunction

    // One tick period: din/arm held, tick high in the last cycle (stall adds idle cycles).
    task automatic step(input bit d, input bit ar, input int stall = 0);
        line_q.push_back(d);
        arm_q.push_back(ar);
        din = d; arm = ar; tick = 1'b0;
        repeat (3 + stall) @(posedge clk);
        #1 tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic add_frame(input logic [7:0] data, inout bit v[$]);
        for (int k = 0; k < NBITS; k++) begin
            bit bv;
            bv = (k == 0) ? 1'b0 : (k == NBITS - 1) ? 1'b1 : data[k-1];
            repeat (OSR) v.push_back(bv);
        end
    endtask

    // Tick-level reference: a frame starts at the first armed tick whose line is low
    // after a high one; bit k is sampled at ticks s+OSR/2+OSR*k .. +2; done at s+OSR*NBITS.
    task automatic model(input int from, input int to, output trip_t eq[$], output int ed[$]);
        int n; bit hunting; bit prev;
        n = from; hunting = 1'b0; prev = 1'b0;
        eq.delete(); ed.delete();
        while (n < to) begin
            if (!arm_q[n]) begin
                hunting = 1'b0;
                n++;
            end else begin
                if (!hunting) begin hunting = 1'b1; prev = 1'b0; end
                if (prev && !line_q[n]) begin
                    for (int k = 0; k < NBITS; k++) begin
                        int t;
                        t = n + OSR / 2 + OSR * k;
                        if (t + 2 < to)
                            eq.push_back('{t + 2, k, line_q[t], line_q[t+1], line_q[t+2]});
                    end
                    n += OSR * NBITS;
                    if (n < to) begin
                        ed.push_back(n);
                        hunting = arm_q[n];
                        prev = 1'b1;
                    end
                    n++;
                end else begin
                    prev = line_q[n];
                    n++;
                end
            end
        end
    endtask

    task automatic collect(input int from, input int to, output trip_t g[$], output int gd[$]);
        g.delete(); gd.delete();
        foreach (got_q[i]) if (got_q[i].tk >= from && got_q[i].tk < to) g.push_back(got_q[i]);
        foreach (done_got[i]) if (done_got[i] >= from && done_got[i] < to) gd.push_back(done_got[i]);
    endtask

    task automatic test_reset();
        int from; bit v[$]; trip_t e[$], g[$]; int ed[$], gd[$];
        rst = 1'b1; din = 1'b0; arm = 1'b1; tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a, b, c, valid, busy, done, bit_idx} !== {3'b111, 3'b000, 4'd0}) begin
            errors++;
            $display("FAIL reset_values: got abc=%b%b%b valid=%b busy=%b done=%b idx=%0d expected abc=111 valid=0 busy=0 done=0 idx=0",
                     a, b, c, valid, busy, done, bit_idx);
        end
        rst = 1'b0; tick = 1'b0;
        from = line_q.size();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_low_line_busy[%0d]: got %b expected 0", i, busy);
            end
        end
        repeat (3) v.push_back(1'b1);
        add_frame(8'($urandom), v);
        repeat (4) v.push_back(1'b1);
        foreach (v[i]) step(v[i], 1'b1);
        repeat (2) step(1'b1, 1'b0);
        model(from, line_q.size(), e, ed);
        collect(from, line_q.size(), g, gd);
        checks++;
        if (g.size() != 10 || e.size() != 10) begin
            errors++;
            $display("FAIL reset_frame_count: got %0d expected 10 (model %0d)", g.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            checks++;
            if (g[i] !== e[i]) begin
                errors++;
                $display("FAIL reset_frame_triple[%0d]: got %s expected %s", i, fmt(g[i]), fmt(e[i]));
            end
        end
    endtask

    task automatic test_clean_frame();
        int from; bit v[$]; trip_t e[$], g[$]; int ed[$], gd[$];
        logic [9:0] pat;
        pat = 10'b1101001010;
        from = line_q.size();
        repeat (3) v.push_back(1'b1);
        add_frame(8'hA5, v);
        repeat (4) v.push_back(1'b1);
        foreach (v[i]) step(v[i], 1'b1);
        repeat (2) step(1'b1, 1'b0);
        model(from, line_q.size(), e, ed);
        collect(from, line_q.size(), g, gd);
        checks++;
        if (g.size() != 10) begin
            errors++;
            $display("FAIL clean_count: got %0d expected 10", g.size());
        end
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            checks++;
            if (g[i] !== e[i] || g[i].idx != i || {g[i].a, g[i].b, g[i].c} !== {3{pat[i]}}) begin
                errors++;
                $display("FAIL clean_triple[%0d]: got %s expected %s", i, fmt(g[i]), fmt(e[i]));
            end
        end
        checks++;
        if (gd.size() != 1 || ed.size() != 1 || gd[0] != ed[0]) begin
            errors++;
            $display("FAIL clean_done: got %0d pulses expected 1 at tick %0d",
                     gd.size(), (ed.size() > 0) ? ed[0] : -1);
        end
        if (gd.size() == 1 && g.size() == 10) begin
            checks++;
            if (gd[0] - g[9].tk != OSR / 2 - 2) begin
                errors++;
                $display("FAIL clean_done_gap: got %0d ticks expected %0d", gd[0] - g[9].tk, OSR / 2 - 2);
            end
        end
    endtask

    task automatic test_glitch();
        int from, s; bit v[$]; trip_t e[$], g[$]; int ed[$], gd[$];
        from = line_q.size();
        repeat (2) v.push_back(1'b1);
        add_frame(8'($urandom) & 8'hFB, v);
        repeat (4) v.push_back(1'b1);
        s = 2;
        v[s + 1 + OSR / 2 + 3 * OSR] = ~v[s + 1 + OSR / 2 + 3 * OSR];
        foreach (v[i]) step(v[i], 1'b1);
        repeat (2) step(1'b1, 1'b0);
        model(from, line_q.size(), e, ed);
        collect(from, line_q.size(), g, gd);
        checks++;
        if (g.size() != e.size()) begin
            errors++;
            $display("FAIL glitch_count: got %0d expected %0d", g.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            checks++;
            if (g[i] !== e[i]) begin
                errors++;
                $display("FAIL glitch_triple[%0d]: got %s expected %s", i, fmt(g[i]), fmt(e[i]));
            end
        end
        if (g.size() > 3) begin
            checks++;
            if ({g[3].a, g[3].b, g[3].c} !== 3'b010 || g[3].idx != 3) begin
                errors++;
                $display("FAIL glitch_bit3: got %s expected idx=3 abc=010", fmt(g[3]));
            end
        end
    endtask

    task automatic test_arm_drop();
        int from, s; bit v[$]; trip_t e[$], g[$]; int ed[$], gd[$]; int late;
        from = line_q.size();
        repeat (3) v.push_back(1'b1);
        add_frame(8'($urandom), v);
        repeat (5) v.push_back(1'b1);
        repeat (20) v.push_back(1'b0);
        repeat (10) v.push_back(1'b1);
        foreach (v[i]) step(v[i], (i < 3 + 4 * OSR + 4) ? 1'b1 : 1'b0);
        s = from + 3;
        model(from, line_q.size(), e, ed);
        collect(from, line_q.size(), g, gd);
        checks++;
        if (g.size() != 10 || e.size() != 10) begin
            errors++;
            $display("FAIL armdrop_count: got %0d expected 10 (model %0d)", g.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            checks++;
            if (g[i] !== e[i]) begin
                errors++;
                $display("FAIL armdrop_triple[%0d]: got %s expected %s", i, fmt(g[i]), fmt(e[i]));
            end
        end
        checks++;
        if (gd.size() != 1) begin
            errors++;
            $display("FAIL armdrop_done: got %0d pulses expected 1", gd.size());
        end
        late = 0;
        foreach (g[i]) if (g[i].tk > s + OSR * NBITS) late++;
        checks++;
        if (late != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL armdrop_idle: got %0d late valids busy=%b expected 0 and 0", late, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int pass = 0; pass < 2; pass++) begin
            int from; bit v[$]; trip_t e[$], g[$]; int ed[$], gd[$]; int w0, c0;
            from = line_q.size();
            w0 = wide; c0 = clash;
            repeat (3) v.push_back(1'b1);
            add_frame(8'($urandom), v);
            add_frame(8'($urandom), v);
            repeat (4) v.push_back(1'b1);
            foreach (v[i]) step(v[i], 1'b1, (pass == 1 && (i % 23) == 11) ? 7 : 0);
            repeat (2) step(1'b1, 1'b0);
            model(from, line_q.size(), e, ed);
            collect(from, line_q.size(), g, gd);
            checks++;
            if (g.size() != 20 || e.size() != 20) begin
                errors++;
                $display("FAIL b2b%0d_count: got %0d expected 20 (model %0d)", pass, g.size(), e.size());
            end
            for (int i = 0; i < e.size() && i < g.size(); i++) begin
                checks++;
                if (g[i] !== e[i]) begin
                    errors++;
                    $display("FAIL b2b%0d_triple[%0d]: got %s expected %s", pass, i, fmt(g[i]), fmt(e[i]));
                end
            end
            checks++;
            if (gd.size() != 2 || ed.size() != 2 || gd[0] != ed[0] || gd[1] != ed[1]) begin
                errors++;
                $display("FAIL b2b%0d_done: got %0d pulses expected 2", pass, gd.size());
            end
            checks++;
            if (wide != w0 || clash != c0) begin
                errors++;
                $display("FAIL b2b%0d_pulse_shape: got wide=%0d clash=%0d expected 0 and 0",
                         pass, wide - w0, clash - c0);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int from, to; bit v[$]; trip_t e[$], g[$]; int ed[$], gd[$];
        from = line_q.size();
        repeat (2) v.push_back(1'b1);
        add_frame(8'($urandom), v);
        for (int i = 0; i <= 2 + 5 * OSR + 8; i++) step(v[i], 1'b1);
        to = line_q.size();
        rst = 1'b1; arm = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({a, b, c, valid, busy, done, bit_idx} !== {3'b111, 3'b000, 4'd0}) begin
            errors++;
            $display("FAIL midreset_values: got abc=%b%b%b valid=%b busy=%b done=%b idx=%0d expected abc=111 valid=0 busy=0 done=0 idx=0",
                     a, b, c, valid, busy, done, bit_idx);
        end
        rst = 1'b0;
        repeat (20) step(1'b1, 1'b0);
        model(from, to, e, ed);
        collect(from, line_q.size(), g, gd);
        checks++;
        if (g.size() != 5 || e.size() != 5 || gd.size() != 0) begin
            errors++;
            $display("FAIL midreset_aborted: got %0d valids %0d dones expected 5 valids 0 dones (model %0d)",
                     g.size(), gd.size(), e.size());
        end
        for (int i = 0; i < e.size() && i < g.size(); i++) begin
            checks++;
            if (g[i] !== e[i]) begin
                errors++;
                $display("FAIL midreset_triple[%0d]: got %s expected %s", i, fmt(g[i]), fmt(e[i]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_frame();
        test_glitch();
        test_arm_drop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
